// File: rtl/ysyx_24100012_pkg.sv
// Shared NPC definitions: ALU select codes, instruction formats, RV32I opcodes
// and funct3 values used by the IDU, ALU and EXU.
package ysyx_24100012_pkg;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'b0000,
        ALU_SUB    = 4'b0001,
        ALU_SLL    = 4'b0010,
        ALU_SLT    = 4'b0011,
        ALU_SLTU   = 4'b0100,
        ALU_XOR    = 4'b0101,
        ALU_SRL    = 4'b0110,
        ALU_SRA    = 4'b0111,
        ALU_OR     = 4'b1000,
        ALU_AND    = 4'b1001,
        ALU_PASS_B = 4'b1010
    } alu_sel_e;

    typedef enum logic [2:0] {
        TYPE_R = 3'b000,
        TYPE_I = 3'b001,
        TYPE_S = 3'b010,
        TYPE_B = 3'b011,
        TYPE_U = 3'b100,
        TYPE_J = 3'b101
    } inst_type_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_B    = 3'b000;
    localparam logic [2:0] F3_H    = 3'b001;
    localparam logic [2:0] F3_W    = 3'b010;
    localparam logic [2:0] F3_BU   = 3'b100;
    localparam logic [2:0] F3_HU   = 3'b101;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [6:0]  F7_BASE     = 7'b0000000;
    localparam logic [6:0]  F7_ALT      = 7'b0100000;
    localparam logic [31:0] INST_EBREAK = 32'h00100073;

    // alt selects SUB over ADD and SRA over SRL (inst[30] in the encoding)
    function automatic alu_sel_e alu_from_f3(input logic [2:0] f3, input logic alt);
        alu_sel_e sel;
        case (f3)
            F3_ADD_SUB: sel = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     sel = ALU_SLL;
            F3_SLT:     sel = ALU_SLT;
            F3_SLTU:    sel = ALU_SLTU;
            F3_XOR:     sel = ALU_XOR;
            F3_SRL_SRA: sel = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      sel = ALU_OR;
            default:    sel = ALU_AND;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/ysyx_24100012_imm_gen.sv
// Combinational immediate generator: extracts and sign-extends the immediate
// of an RV32I instruction according to its format.
module ysyx_24100012_imm_gen
    import ysyx_24100012_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] inst,
    input  inst_type_e            inst_type,
    output logic [DATA_WIDTH-1:0] imm
);

    logic signed [31:0] imm32;
    logic               unused_opcode;

    assign unused_opcode = ^inst[6:0];

    always_comb begin
        imm32 = '0;
        case (inst_type)
            TYPE_I:  imm32 = {{20{inst[31]}}, inst[31:20]};
            TYPE_S:  imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            TYPE_B:  imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            TYPE_U:  imm32 = {inst[31:12], 12'b0};
            TYPE_J:  imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // signed source, so the size cast sign-extends for wider datapaths
    assign imm = DATA_WIDTH'(imm32);

endmodule

// File: rtl/ysyx_24100012_idu.sv
// NPC instruction decode unit: valid/ready skid-free holding register feeding the EXU.
// Define YSYX_24100012_EBREAK_EN to decode EBREAK instead of flagging it illegal.
module ysyx_24100012_idu
    import ysyx_24100012_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N_SEL      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_inst,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic                  flush,
    output logic [4:0]            rs1_addr,
    output logic [4:0]            rs2_addr,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_a,
    output logic [DATA_WIDTH-1:0] out_b,
    output logic [DATA_WIDTH-1:0] out_imm,
    output logic [DATA_WIDTH-1:0] out_rs2_data,
    output logic [N_SEL-1:0]      out_alu_sel,
    output logic [2:0]            out_inst_type,
    output logic [4:0]            out_rd,
    output logic                  out_wen,
    output logic                  out_illegal,
    output logic                  out_ebreak
);

    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_e;

    state_e state_q, state_d;
    logic   accept, load;

    logic [6:0] opcode, f7;
    logic [2:0] f3;
    logic [4:0] rd;

    inst_type_e            type_d, type_q;
    alu_sel_e              sel_d, sel_q;
    logic [DATA_WIDTH-1:0] imm_d, a_d, b_d;
    logic [DATA_WIDTH-1:0] pc_q, a_q, b_q, imm_q, rs2d_q;
    logic [4:0]            rd_q;
    logic                  legal, wen_raw, wen_d, wen_q, ill_q;
`ifdef YSYX_24100012_EBREAK_EN
    logic                  ebreak_d, ebreak_q;
`endif

    assign opcode   = in_inst[6:0];
    assign rd       = in_inst[11:7];
    assign f3       = in_inst[14:12];
    assign f7       = in_inst[31:25];
    assign rs1_addr = in_inst[19:15];
    assign rs2_addr = in_inst[24:20];

    assign out_valid = (state_q == S_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign load      = accept && !flush;

    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_EMPTY;
        else      state_q <= state_d;
    end

    // flush wins over a same-cycle accept; a drained entry empties the register
    always_comb begin
        state_d = state_q;
        if (flush)          state_d = S_EMPTY;
        else if (accept)    state_d = S_FULL;
        else if (out_ready) state_d = S_EMPTY;
    end

    // Format depends on opcode alone, keeping imm_gen out of the decode loop.
    always_comb begin
        type_d = TYPE_R;
        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: type_d = TYPE_I;
            OPC_STORE:                                  type_d = TYPE_S;
            OPC_BRANCH:                                 type_d = TYPE_B;
            OPC_LUI, OPC_AUIPC:                         type_d = TYPE_U;
            OPC_JAL:                                    type_d = TYPE_J;
            default:                                    type_d = TYPE_R;
        endcase
    end

    ysyx_24100012_imm_gen #(.DATA_WIDTH(DATA_WIDTH)) u_imm_gen (
        .inst      (in_inst),
        .inst_type (type_d),
        .imm       (imm_d)
    );

    always_comb begin
        legal   = 1'b0;
        sel_d   = ALU_ADD;
        a_d     = '0;
        b_d     = '0;
        wen_raw = 1'b0;
`ifdef YSYX_24100012_EBREAK_EN
        ebreak_d = 1'b0;
`endif
        case (opcode)
            OPC_OP: begin
                legal   = (f7 == F7_BASE) ||
                          (f7 == F7_ALT && (f3 == F3_ADD_SUB || f3 == F3_SRL_SRA));
                sel_d   = alu_from_f3(f3, f7[5]);
                a_d     = rs1_data;
                b_d     = rs2_data;
                wen_raw = 1'b1;
            end
            OPC_OP_IMM: begin
                if (f3 == F3_SLL)          legal = (f7 == F7_BASE);
                else if (f3 == F3_SRL_SRA) legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                else                       legal = 1'b1;
                sel_d   = alu_from_f3(f3, (f3 == F3_SRL_SRA) && in_inst[30]);
                a_d     = rs1_data;
                b_d     = (f3 == F3_SLL || f3 == F3_SRL_SRA) ? DATA_WIDTH'(imm_d[4:0]) : imm_d;
                wen_raw = 1'b1;
            end
            OPC_LOAD: begin
                legal   = f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
                a_d     = rs1_data;
                b_d     = imm_d;
                wen_raw = 1'b1;
            end
            OPC_STORE: begin
                legal = f3 inside {F3_B, F3_H, F3_W};
                a_d   = rs1_data;
                b_d   = imm_d;
            end
            OPC_BRANCH: begin
                legal = f3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU};
                case (f3)
                    F3_BLT, F3_BGE:   sel_d = ALU_SLT;
                    F3_BLTU, F3_BGEU: sel_d = ALU_SLTU;
                    default:          sel_d = ALU_SUB;
                endcase
                a_d = rs1_data;
                b_d = rs2_data;
            end
            OPC_JAL: begin
                legal   = 1'b1;
                a_d     = in_pc;
                b_d     = imm_d;
                wen_raw = 1'b1;
            end
            OPC_JALR: begin
                legal   = (f3 == F3_JALR);
                a_d     = rs1_data;
                b_d     = imm_d;
                wen_raw = 1'b1;
            end
            OPC_LUI: begin
                legal   = 1'b1;
                sel_d   = ALU_PASS_B;
                b_d     = imm_d;
                wen_raw = 1'b1;
            end
            OPC_AUIPC: begin
                legal   = 1'b1;
                a_d     = in_pc;
                b_d     = imm_d;
                wen_raw = 1'b1;
            end
`ifdef YSYX_24100012_EBREAK_EN
            OPC_SYSTEM: begin
                if (in_inst[31:0] == INST_EBREAK) begin
                    legal    = 1'b1;
                    ebreak_d = 1'b1;
                end
            end
`endif
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            sel_d   = ALU_ADD;
            a_d     = '0;
            b_d     = '0;
            wen_raw = 1'b0;
        end
    end

    assign wen_d = wen_raw && (rd != 5'd0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            imm_q  <= '0;
            rs2d_q <= '0;
            sel_q  <= ALU_ADD;
            type_q <= TYPE_R;
            rd_q   <= '0;
            wen_q  <= 1'b0;
            ill_q  <= 1'b0;
        end else if (load) begin
            pc_q   <= in_pc;
            a_q    <= a_d;
            b_q    <= b_d;
            imm_q  <= imm_d;
            rs2d_q <= rs2_data;
            sel_q  <= sel_d;
            type_q <= type_d;
            rd_q   <= rd;
            wen_q  <= wen_d;
            ill_q  <= !legal;
        end
    end

`ifdef YSYX_24100012_EBREAK_EN
    always_ff @(posedge clk) begin
        if (!rst)      ebreak_q <= 1'b0;
        else if (load) ebreak_q <= ebreak_d;
    end
    assign out_ebreak = ebreak_q;
`else
    assign out_ebreak = 1'b0;
`endif

    assign out_pc        = pc_q;
    assign out_a         = a_q;
    assign out_b         = b_q;
    assign out_imm       = imm_q;
    assign out_rs2_data  = rs2d_q;
    assign out_alu_sel   = N_SEL'(sel_q);
    assign out_inst_type = type_q;
    assign out_rd        = rd_q;
    assign out_wen       = wen_q;
    assign out_illegal   = ill_q;

endmodule
